// File: rtl/ram_alu_sequencer.sv
// Memory-to-memory ALU sequencer for the dual-port RAM: fetches two operands,
// applies the latched op and writes the result back, one command per 4 cycles.
//
// state   | meaning
// IDLE    | cmd_ready=1, waiting for cmd_valid
// FETCH   | addresses presented, RAM samples them at end of cycle
// CAPTURE | read data valid, result/carry registered
// WRITE   | write strobe (or error pulse for reserved op), done=1
module ram_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_z,
  output logic [ADDR_W-1:0] ram_addr_a,
  input  logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_c,
  output logic [DATA_W-1:0] ram_data_c,
  output logic              ram_we_c,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;

  logic [1:0]      state;
  logic [2:0]      op;
  logic            op_rsvd;
  logic [DATA_W:0] alu;

  // ops 6 and 7 are reserved
  assign op_rsvd = op[2] & op[1];

  always_comb begin
    alu = '0;
    case (op)
      3'd0:    alu = {1'b0, ram_data_a} + {1'b0, ram_data_b};
      3'd1:    alu = {1'b0, ram_data_a} - {1'b0, ram_data_b};
      3'd2:    alu = {1'b0, ram_data_a & ram_data_b};
      3'd3:    alu = {1'b0, ram_data_a | ram_data_b};
      3'd4:    alu = {1'b0, ram_data_a ^ ram_data_b};
      3'd5:    alu = {1'b0, ram_data_a};
      default: alu = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      op         <= '0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_addr_c <= '0;
      ram_data_c <= '0;
      result     <= '0;
      carry      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ram_addr_a <= cmd_addr_a;
            ram_addr_b <= cmd_addr_b;
            ram_addr_c <= cmd_addr_z;
            op         <= cmd_op;
            state      <= FETCH;
          end
        end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          if (!op_rsvd) begin
            ram_data_c <= alu[DATA_W-1:0];
            result     <= alu[DATA_W-1:0];
            carry      <= alu[DATA_W];
          end
          state <= WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // strobes decode from state so reset kills a pending write immediately
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == WRITE);
  assign err       = (state == WRITE) & op_rsvd;
  assign ram_we_c  = (state == WRITE) & ~op_rsvd;

endmodule

// File: tb/tb_ram_alu_sequencer.sv
// Bench for ram_alu_sequencer: behavioural RAM, command-level reference model,
// per-cycle output compare, directed cases and randomized traffic.
module tb_ram_alu_sequencer;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_addr_a = 8'd0, cmd_addr_b = 8'd0, cmd_addr_z = 8'd0;
  logic [7:0] ram_addr_a, ram_addr_b, ram_addr_c, ram_data_c;
  logic [7:0] ram_data_a = 8'd0, ram_data_b = 8'd0;
  logic       ram_we_c, done, err, carry, busy;
  logic [7:0] result;

  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'd0, poke_data = 8'd0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ram_alu_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_z(cmd_addr_z),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b),
    .ram_addr_c(ram_addr_c), .ram_data_c(ram_data_c), .ram_we_c(ram_we_c),
    .done(done), .err(err), .result(result), .carry(carry), .busy(busy)
  );

  // Behavioural RAM: registered reads, write commits at the clock edge
  logic [7:0] mem [256];
  always @(posedge CLK) begin
    ram_data_a <= mem[ram_addr_a];
    ram_data_b <= mem[ram_addr_b];
    if (ram_we_c) mem[ram_addr_c] <= ram_data_c;
    if (poke_en)  mem[poke_addr]  <= poke_data;
  end

  // {reserved, carry, result} from plain arithmetic
  function automatic logic [9:0] alu_ref(input int op, input int a, input int b);
    int s;
    logic c;
    c = 1'b0;
    case (op)
      0: begin s = a + b; c = (s > 255); end
      1: begin s = a - b; c = (a < b); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = a;
      default: return {1'b1, 9'd0};
    endcase
    s = ((s % 256) + 256) % 256;
    return {1'b0, c, 8'(s)};
  endfunction

  // Command-level model: phase counts cycles since acceptance (0 = idle)
  logic [7:0] ref_mem [256];
  int         phase;
  logic [7:0] m_a, m_b, m_z, m_res, m_dc, t_res;
  logic       m_car, t_car, t_rsvd;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= 0;
      m_a <= 8'd0; m_b <= 8'd0; m_z <= 8'd0;
      m_res <= 8'd0; m_dc <= 8'd0; m_car <= 1'b0;
      t_res <= 8'd0; t_car <= 1'b0; t_rsvd <= 1'b0;
    end else begin
      if (poke_en) ref_mem[poke_addr] <= poke_data;
      case (phase)
        0: if (cmd_valid) begin
          {t_rsvd, t_car, t_res} <= alu_ref(int'(cmd_op), int'(ref_mem[cmd_addr_a]),
                                            int'(ref_mem[cmd_addr_b]));
          m_a <= cmd_addr_a; m_b <= cmd_addr_b; m_z <= cmd_addr_z;
          phase <= 1;
        end
        1: phase <= 2;
        2: begin
          phase <= 3;
          if (!t_rsvd) begin m_res <= t_res; m_car <= t_car; m_dc <= t_res; end
        end
        default: begin
          phase <= 0;
          if (!t_rsvd) ref_mem[m_z] <= t_res;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("cmd_ready",  cmd_ready,  phase == 0);
    chk("busy",       busy,       phase != 0);
    chk("done",       done,       phase == 3);
    chk("err",        err,        (phase == 3) && t_rsvd);
    chk("ram_we_c",   ram_we_c,   (phase == 3) && !t_rsvd);
    chk("ram_addr_a", ram_addr_a, m_a);
    chk("ram_addr_b", ram_addr_b, m_b);
    chk("ram_addr_c", ram_addr_c, m_z);
    chk("ram_data_c", ram_data_c, m_dc);
    chk("result",     result,     m_res);
    chk("carry",      carry,      m_car);
  end

  task automatic poke(input logic [7:0] ad, input logic [7:0] dt);
    @(negedge CLK);
    poke_en = 1'b1; poke_addr = ad; poke_data = dt;
    @(negedge CLK);
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic scramble_cmd();
    cmd_op     = 3'($urandom);
    cmd_addr_a = 8'($urandom);
    cmd_addr_b = 8'($urandom);
    cmd_addr_z = 8'($urandom);
  endtask

  // Issue from idle; returns negedges from acceptance to done and err at done
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] z, output int lat, output logic e);
    wait_idle();
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_z = z; cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    scramble_cmd();
    lat = -1;
    e = 1'b0;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      if (done) begin lat = i; e = err; end
      else @(negedge CLK);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, d1, d2;
    logic e;

    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    repeat (10) @(negedge CLK);
    chk("reset_ready",  cmd_ready, 1);
    chk("reset_busy",   busy,      0);
    chk("reset_result", result,    0);

    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      poke_en = 1'b1; poke_addr = 8'(i); poke_data = 8'($urandom);
    end
    @(negedge CLK);
    poke_en = 1'b0;

    // ADD with wrap
    poke(8'h10, 8'hF0);
    poke(8'h11, 8'h20);
    run_cmd(3'd0, 8'h10, 8'h11, 8'h12, lat, e);
    chk("add_latency", lat, 3);
    chk("add_result",  result, 8'h10);
    chk("add_carry",   carry, 1);
    wait_idle();
    chk("add_mem", mem[8'h12], 8'h10);

    // SUB with borrow, z aliases a
    poke(8'h05, 8'h03);
    poke(8'h06, 8'h05);
    run_cmd(3'd1, 8'h05, 8'h06, 8'h05, lat, e);
    chk("sub_latency", lat, 3);
    chk("sub_carry",   carry, 1);
    wait_idle();
    chk("sub_mem", mem[8'h05], 8'hFE);

    // Back-to-back with read-after-write
    poke(8'h01, 8'hAA);
    poke(8'h02, 8'h0F);
    wait_idle();
    cmd_op = 3'd4; cmd_addr_a = 8'h01; cmd_addr_b = 8'h02; cmd_addr_z = 8'h03;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_op = 3'd5; cmd_addr_a = 8'h03; cmd_addr_b = 8'h77; cmd_addr_z = 8'h04;
    d1 = -1; d2 = -1;
    for (int n = 1; n <= 12; n++) begin
      if (done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (n == 5) cmd_valid = 1'b0;
      @(negedge CLK);
    end
    chk("b2b_done1", d1, 3);
    chk("b2b_done2", d2, 7);
    chk("b2b_mem3", mem[8'h03], 8'hA5);
    chk("b2b_mem4", mem[8'h04], 8'hA5);

    // Reserved op: error pulse, no write, result held
    poke(8'h20, 8'h5A);
    run_cmd(3'd6, 8'h20, 8'h21, 8'h20, lat, e);
    chk("rsvd_latency", lat, 3);
    chk("rsvd_err",     e, 1);
    chk("rsvd_result",  result, 8'hA5);
    chk("rsvd_carry",   carry, 0);
    wait_idle();
    chk("rsvd_mem", mem[8'h20], 8'h5A);

    // Reset during CAPTURE abandons the write
    poke(8'h30, 8'h01);
    poke(8'h31, 8'h02);
    poke(8'h32, 8'h77);
    wait_idle();
    cmd_op = 3'd0; cmd_addr_a = 8'h30; cmd_addr_b = 8'h31; cmd_addr_z = 8'h32;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_mem",   mem[8'h32], 8'h77);
    run_cmd(3'd0, 8'h30, 8'h31, 8'h32, lat, e);
    chk("rst_next_latency", lat, 3);
    wait_idle();
    chk("rst_next_mem", mem[8'h32], 8'h03);

    // Randomized traffic over a small address window for heavy aliasing
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_op     = 3'($urandom);
      cmd_addr_a = 8'($urandom_range(0, 15));
      cmd_addr_b = 8'($urandom_range(0, 15));
      cmd_addr_z = 8'($urandom_range(0, 15));
    end
    cmd_valid = 1'b0;
    wait_idle();
    @(negedge CLK);
    for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_alu_sequencer.md
Name: ram_alu_sequencer

Overview:
Memory-to-memory operation sequencer for the team's 8-bit dual-port RAM, which has two registered read ports (A, B) and one write port (C). It accepts one command per valid/ready handshake: read operands at two addresses, apply an ALU op, and write the result to a third address. It owns all RAM address and write-enable lines and sits between the instruction front end and the RAM.

Parameters:
DATA_W, 8, operand/result width (RAM word width)
ADDR_W, 8, RAM address width (256 words)

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 PASS A, 6/7 reserved
cmd_addr_a  in  ADDR_W  operand A address
cmd_addr_b  in  ADDR_W  operand B address
cmd_addr_z  in  ADDR_W  result address
ram_addr_a  out  ADDR_W  to RAM port A address
ram_data_a  in  DATA_W  from RAM port A data (registered, 1-cycle latency)
ram_addr_b  out  ADDR_W  to RAM port B address
ram_data_b  in  DATA_W  from RAM port B data
ram_addr_c  out  ADDR_W  to RAM write address
ram_data_c  out  DATA_W  to RAM write data
ram_we_c  out  1  to RAM write enable
done  out  1  one-cycle pulse: command completed (written or rejected)
err  out  1  one-cycle pulse with done: reserved op, no write performed
result  out  DATA_W  last computed result, held until next completion
carry  out  1  ADD carry-out / SUB borrow of last completion; 0 for logic ops
busy  out  1  high in every non-IDLE state

Behaviour:
- Reset (async, RST=1): state=IDLE. All address, ram_data_c, result and latched-op registers are 0. ram_we_c, done, err, carry and busy are 0. cmd_ready is 1 after reset deasserts.
- Reset asserted mid-command: the command is abandoned. ram_we_c drops immediately and no partial write occurs.
- All outputs are registered or decoded directly from state. There is no combinational path from cmd_* to any output.
- FSM states: IDLE, FETCH, CAPTURE, WRITE.
- IDLE: cmd_ready=1. When cmd_valid is high at a rising edge, latch cmd_addr_a/b/z into ram_addr_a/b/c, latch cmd_op, and go to FETCH. cmd_valid low: stay in IDLE.
- FETCH: cmd_ready=0. The RAM samples the addresses at the end of this cycle. Go to CAPTURE.
- CAPTURE: ram_data_a/b are valid.
  - Valid op: compute the result in DATA_W+1 bits; register ram_data_c=result[DATA_W-1:0], result, and carry. Go to WRITE.
  - Reserved op: no register update.
- WRITE, valid op: ram_we_c=1 and done=1 for exactly this cycle. The write commits at the end of this cycle. Go to IDLE.
- WRITE, reserved op: ram_we_c=0, done=1, err=1. result and carry are unchanged. Go to IDLE.
- Arithmetic: all ops are modulo 2^DATA_W.
  - ADD: carry=bit DATA_W of A+B.
  - SUB: carry=1 when A<B (borrow).
  - Logic ops and PASS A: carry=0.
- Latency: acceptance edge T0; FETCH, CAPTURE and WRITE occupy cycles T0+1..T0+3; done is high in cycle T0+3; cmd_ready is high again in cycle T0+4.
- Throughput: one command per 4 cycles. There is no back-to-back acceptance.
- Address aliasing is legal in any combination (a=b, z=a, z=b, all equal). Operands are the pre-write values.
- Read-after-write: a following command's FETCH is at least 2 cycles after the previous write commits, so it always reads the new value. No forwarding is needed.
- cmd_valid while busy is ignored. cmd_* fields may change freely outside the acceptance edge.
- ram_addr_a/b/c hold their latched values until the next acceptance.

Test Plan:
- Reset then idle: RST pulse, cmd_valid=0 for 10 cycles -> cmd_ready=1, busy=0, ram_we_c never high, all outputs 0.
- ADD with wrap: preload mem[0x10]=0xF0, mem[0x11]=0x20; cmd op=0, a=0x10, b=0x11, z=0x12 -> done in cycle T0+3, mem[0x12]=0x10, carry=1, result=0x10.
- SUB borrow with alias z=a: mem[5]=0x03, mem[6]=0x05; op=1, a=5, b=6, z=5 -> mem[5]=0xFE, carry=1.
- Back-to-back RAW: hold cmd_valid high with cmd1 XOR (a=1, b=2, z=3), then cmd2 PASS A (a=3, z=4); mem[1]=0xAA, mem[2]=0x0F -> cmd2 accepted exactly 4 cycles after cmd1, mem[3]=0xA5, mem[4]=0xA5.
- Reserved op: op=6 -> done=1 and err=1 in cycle T0+3, ram_we_c stays 0, result unchanged, RAM contents unchanged.
- Reset mid-op: assert RST during CAPTURE of an ADD -> ram_we_c never asserts, target word unchanged, after release cmd_ready=1 and the next command completes normally.
